// File: rtl/exu_alu_core.sv
// Execute-stage ALU: single-cycle ops finish in one cycle, MUL iterates shift-add over WIDTH cycles.
// One operation in flight; valid/ready on both the operand side and the result side.
module exu_alu_core #(
  parameter int WIDTH      = 32,
  parameter int FUNC_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      alu_a,
  input  logic [WIDTH-1:0]      alu_b,
  input  logic [FUNC_WIDTH-1:0] alu_func,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      alu_result,
  output logic                  busy
);

  localparam logic [FUNC_WIDTH-1:0] F_NO_FUNC = FUNC_WIDTH'(0);
  localparam logic [FUNC_WIDTH-1:0] F_ADD     = FUNC_WIDTH'(1);
  localparam logic [FUNC_WIDTH-1:0] F_SUB     = FUNC_WIDTH'(2);
  localparam logic [FUNC_WIDTH-1:0] F_EQ      = FUNC_WIDTH'(3);
  localparam logic [FUNC_WIDTH-1:0] F_NE      = FUNC_WIDTH'(4);
  localparam logic [FUNC_WIDTH-1:0] F_LESS_U  = FUNC_WIDTH'(5);
  localparam logic [FUNC_WIDTH-1:0] F_LESS_S  = FUNC_WIDTH'(6);
  localparam logic [FUNC_WIDTH-1:0] F_AND     = FUNC_WIDTH'(7);
  localparam logic [FUNC_WIDTH-1:0] F_OR      = FUNC_WIDTH'(8);
  localparam logic [FUNC_WIDTH-1:0] F_XOR     = FUNC_WIDTH'(9);
  localparam logic [FUNC_WIDTH-1:0] F_SLL     = FUNC_WIDTH'(10);
  localparam logic [FUNC_WIDTH-1:0] F_SRL     = FUNC_WIDTH'(11);
  localparam logic [FUNC_WIDTH-1:0] F_SRA     = FUNC_WIDTH'(12);
  localparam logic [FUNC_WIDTH-1:0] F_MUL     = FUNC_WIDTH'(13);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             accept;

  assign shamt = alu_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_func)
      F_ADD:    alu_res = alu_a + alu_b;
      F_SUB:    alu_res = alu_a - alu_b;
      F_EQ:     alu_res = {{(WIDTH-1){1'b0}}, alu_a == alu_b};
      F_NE:     alu_res = {{(WIDTH-1){1'b0}}, alu_a != alu_b};
      F_LESS_U: alu_res = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
      F_LESS_S: alu_res = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      F_AND:    alu_res = alu_a & alu_b;
      F_OR:     alu_res = alu_a | alu_b;
      F_XOR:    alu_res = alu_a ^ alu_b;
      F_SLL:    alu_res = alu_a << shamt;
      F_SRL:    alu_res = alu_a >> shamt;
      F_SRA:    alu_res = WIDTH'($signed(alu_a) >>> shamt);
      F_NO_FUNC: alu_res = '0;
      default:  alu_res = '0;
    endcase
  end

  // in_ready comes straight from the state flop; flush only gates the accept itself.
  assign accept = in_valid && (state_q == ST_IDLE) && !flush;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (alu_func == F_MUL) begin
            mcand_d  = alu_a;
            mplier_d = alu_b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            res_d   = alu_res;
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = acc_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort drops any partial product but leaves the last delivered result in place.
    if (flush) begin
      state_d  = ST_IDLE;
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
      cnt_d    = '0;
      res_d    = res_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q == ST_MUL) || (state_q == ST_DONE);
  assign alu_result = res_q;

endmodule

// File: tb/tb_exu_alu_core.sv
// Directed bench for exu_alu_core: hand-computed vectors, latency, back-pressure, flush and async reset.
module tb_exu_alu_core;

  localparam int W = 32;
  localparam logic [3:0] F_NO_FUNC = 4'd0,  F_ADD = 4'd1,  F_SUB = 4'd2,  F_EQ = 4'd3;
  localparam logic [3:0] F_NE = 4'd4,  F_LESS_U = 4'd5, F_LESS_S = 4'd6, F_AND = 4'd7;
  localparam logic [3:0] F_OR = 4'd8,  F_XOR = 4'd9,  F_SLL = 4'd10, F_SRL = 4'd11;
  localparam logic [3:0] F_SRA = 4'd12, F_MUL = 4'd13, F_UNDEF = 4'd15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  alu_a = '0;
  logic [W-1:0]  alu_b = '0;
  logic [3:0]    alu_func = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  alu_result;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  exu_alu_core #(.WIDTH(W), .FUNC_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the result handshake.
  task automatic run_op(input string tag, input logic [3:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
    int n;
    alu_func = f; alu_a = a; alu_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, W'(n), W'(exp_lat));
    check(tag, alu_result, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    #3;
    check("rst_in_ready", W'(in_ready), 1);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_busy", W'(busy), 0);
    check("rst_result", alu_result, 0);
    #14 rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_wrap", F_ADD, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 0);
    run_op("sub", F_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0);
    run_op("eq", F_EQ, 32'h8000_0000, 32'd1, 32'd0, 0);
    run_op("ne", F_NE, 32'h8000_0000, 32'd1, 32'd1, 0);
    run_op("less_u", F_LESS_U, 32'h8000_0000, 32'd1, 32'd0, 0);
    run_op("less_s", F_LESS_S, 32'h8000_0000, 32'd1, 32'd1, 0);
    run_op("sra", F_SRA, 32'h8000_0000, 32'd1, 32'hC000_0000, 0);
    run_op("srl", F_SRL, 32'h8000_0000, 32'd1, 32'h4000_0000, 0);
    run_op("sll_mask", F_SLL, 32'h8000_0000, 32'h21, 32'h0000_0000, 0);
    run_op("and", F_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0);
    run_op("or", F_OR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 0);
    run_op("xor", F_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 0);
    run_op("mul_small", F_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, W);
    run_op("mul_ones", F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, W);

    // Back-pressure: hold ADD 3+4 for 5 cycles while a SUB knocks on the door.
    out_ready = 1'b0;
    alu_func = F_ADD; alu_a = 32'd3; alu_b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_func = F_SUB; alu_a = 32'd9; alu_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", W'(out_valid), 1);
      check("bp_result", alu_result, 32'd7);
      check("bp_in_ready", W'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_in_ready", W'(in_ready), 1);
    check("bp_idle_out_valid", W'(out_valid), 0);
    check("bp_idle_result", alu_result, 32'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", W'(out_valid), 1);
    check("bp_next_result", alu_result, 32'd8);
    @(posedge clk); #1;

    // Flush on the 10th MUL cycle; the result register keeps the last value (8).
    alu_func = F_MUL; alu_a = 32'd7; alu_b = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      check("fl_busy", W'(busy), 1);
      check("fl_no_valid", W'(out_valid), 0);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_in_ready", W'(in_ready), 1);
    check("fl_busy_clr", W'(busy), 0);
    check("fl_out_valid", W'(out_valid), 0);
    check("fl_result_kept", alu_result, 32'd8);
    // flush in IDLE masks an accept
    alu_func = F_ADD; alu_a = 32'd5; alu_b = 32'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("fl_idle_no_accept", W'(out_valid), 0);
    check("fl_idle_in_ready", W'(in_ready), 1);
    run_op("add_after_flush", F_ADD, 32'd1, 32'd1, 32'd2, 0);

    // Async reset mid-MUL: outputs clear without a clock edge.
    alu_func = F_MUL; alu_a = 32'd7; alu_b = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    check("ar_busy_before", W'(busy), 1);
    #1 rst = 1'b1;
    #1;
    check("ar_in_ready", W'(in_ready), 1);
    check("ar_out_valid", W'(out_valid), 0);
    check("ar_busy", W'(busy), 0);
    check("ar_result", alu_result, 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) n++;
      @(posedge clk); #1;
    end
    check("ar_no_result", W'(n), 0);

    run_op("mul_after_rst", F_MUL, 32'd7, 32'd6, 32'd42, W);
    run_op("undef_func", F_UNDEF, 32'h1234_5678, 32'h1111_1111, 32'd0, 0);
    run_op("add_nz", F_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 0);
    run_op("no_func", F_NO_FUNC, 32'h1234_5678, 32'h1111_1111, 32'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_alu_core.md
# exu_alu_core

Multi-cycle ALU datapath at the execute stage. It is the consumer of the operand/function selection logic: it accepts `alu_a`, `alu_b` and `alu_func` under a valid/ready handshake and returns `alu_result` under a second valid/ready handshake. Single-cycle operations complete in one cycle. MUL runs an iterative shift-add over WIDTH cycles. One operation is outstanding at a time.

## Interface
Parameters:
- WIDTH, default `ISA_WIDTH` (32): operand and result width.
- FUNC_WIDTH, default `ALU_FUNC_WIDTH`: width of the function code.

Function codes are the `config.v` macros. `config.v` gains the new codes LESS_S, AND, OR, XOR, SLL, SRL, SRA and MUL alongside the existing NO_FUNC, ADD, SUB, EQ, NE and LESS_U.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous abort of any in-flight or held operation.
- in_valid  in  1  operands and function are presented.
- in_ready  out  1  block can accept; high only in IDLE.
- alu_a  in  WIDTH  operand A.
- alu_b  in  WIDTH  operand B.
- alu_func  in  FUNC_WIDTH  function code.
- out_valid  out  1  alu_result is valid.
- out_ready  in  1  consumer takes the result.
- alu_result  out  WIDTH  registered result.
- busy  out  1  high in MUL or DONE.

## Operation
States are IDLE, MUL and DONE. in_ready = (state==IDLE). out_valid = (state==DONE).

IDLE:
- An accept is in_valid && in_ready at a rising edge.
- If func != MUL: the result is computed combinationally from the inputs and registered into alu_result; next state is DONE.
- If func == MUL: load mcand=alu_a, mplier=alu_b, acc=0, cnt=0; next state is MUL.

MUL, per cycle:
- If mplier[0], acc += mcand (modulo 2^WIDTH).
- mcand <<= 1; mplier >>= 1; cnt++.
- When cnt == WIDTH-1 on the current cycle, the final acc is written to alu_result and next state is DONE.
- The iteration count is fixed at WIDTH; there is no early termination.

DONE:
- alu_result is held stable while out_valid is high.
- When out_ready is high at the edge, next state is IDLE.
- No new accept happens in the same cycle (in_ready is 0).

Function results (all arithmetic modulo 2^WIDTH):
- ADD: a+b. SUB: a-b.
- EQ: {0…,a==b}. NE: {0…,a!=b}.
- LESS_U: unsigned a<b. LESS_S: signed a<b. Comparison results are 0 or 1, zero-extended.
- AND, OR, XOR: bitwise.
- SLL, SRL, SRA: shift amount is b[$clog2(WIDTH)-1:0]; SRA sign-fills from a[WIDTH-1].
- MUL: low WIDTH bits of a*b (identical for signed and unsigned).
- NO_FUNC and any undefined code: result 0, with a normal handshake completion.

Flush (sync) has priority over every transition except rst:
- Next state is IDLE, and the MUL registers are cleared.
- alu_result keeps its last value.
- An in_valid presented in the same cycle as flush is not accepted, even in IDLE. Effectively in_ready is masked by flush.

Reset (async), from any state:
- State goes to IDLE immediately; acc, mcand, mplier, cnt and alu_result go to 0.
- out_valid goes to 0 and busy to 0; in_ready is 1 once state==IDLE, including while rst is held.

## Timing
- Non-MUL latency: accept at edge N → out_valid high after edge N+1 … edge N → out_valid visible during cycle N+1. The earliest out_ready handshake is edge N+1.
- MUL latency: accept at edge N → MUL spans cycles N+1 … N+WIDTH → out_valid visible from cycle N+WIDTH+1.
- Throughput: one op per (latency + 1) cycles at best, because IDLE costs at least one cycle between ops.
- in_ready and out_valid are decoded from the state register only. There are no combinational paths from in_valid or out_ready to any output.
- Back-pressure: out_ready low holds DONE indefinitely, with alu_result and out_valid stable.
- in_valid while in MUL or DONE is ignored, and the upstream must hold its inputs.
- flush or rst mid-MUL discards the partial product; no result is produced.

## Test plan
- After reset, check in_ready=1, out_valid=0, alu_result=0. Then ADD a=0xFFFF_FFFF, b=2 → result 0x0000_0001 one cycle after accept, with out_ready tied high.
- Sweep SUB/EQ/NE/LESS_U/LESS_S/SRA with a=0x8000_0000, b=1:
  - SUB → 0x7FFF_FFFF. EQ → 0. NE → 1.
  - LESS_U → 0. LESS_S → 1.
  - SRA → 0xC000_0000. Also SLL with b=0x21 → 0x0000_0000 (shift amount 1 of 0x8000_0000).
- MUL a=0x0001_0003, b=0x0000_0005 → 0x0005_000F with out_valid exactly WIDTH+1 cycles after accept. MUL 0xFFFF_FFFF × 0xFFFF_FFFF → 0x0000_0001.
- Back-pressure: ADD 3+4 with out_ready low for 5 cycles. out_valid stays high with 7 stable and in_ready stays 0. A new in_valid during the stall is not accepted; after out_ready, it is accepted only from IDLE.
- Abort mid-MUL:
  - Flush asserted at cycle 10 of a MUL → IDLE the next cycle with out_valid never asserted; a following ADD 1+1 returns 2.
  - Repeat the MUL with an async rst pulse mid-cycle: outputs go to their reset values immediately, without waiting for a clock edge.
- Undefined func code (all ones) and NO_FUNC → result 0, with a normal one-cycle completion.
